// File: rtl/tx_pkt_admit.sv
// rtl/tx_pkt_admit.sv - LMAC TX packet admission stage ahead of the TX packet-data FIFO
module tx_pkt_admit #(
  parameter int DEPTH_QWD = 32,
  parameter int LEN_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [LEN_W-1:0]  in_len,
  output logic              tx_we,
  output logic [63:0]       tx_data,
  input  logic              tx_full,
  input  logic [12:0]       tx_usedw,
  output logic              len_err,
  output logic              sop_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, DROP} state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_QWD);

  state_t           state;
  logic [LEN_W-1:0] exp_cnt;   // qwords still owed to the FIFO for this frame

  logic [LEN_W-1:0] need;
  logic [LEN_W-1:0] occ;
  logic [LEN_W-1:0] free;
  logic             len_ok;
  logic             fits;
  logic             accept;
  logic [63:0]      header;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Space check: ceil without a +7 so large lengths cannot wrap; the in-flight write is charged against free space
  always_comb begin
    need   = (in_len >> 3) + LEN_W'(|in_len[2:0]) + LEN_W'(1);
    occ    = LEN_W'(tx_usedw) + LEN_W'(tx_we);
    free   = (occ >= DEPTH_L) ? '0 : DEPTH_L - occ;
    len_ok = (in_len != '0) && (need <= DEPTH_L);
    fits   = (need <= free);
    header = {1'b1, {(63-LEN_W){1'b0}}, in_len};
  end

  // Beat acceptance per state; the sop beat is held in IDLE until it can be resolved
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = in_valid & ~in_sop;
        DATA:    in_ready = ~tx_full;
        PAD:     in_ready = 1'b0;
        DROP:    in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // Frame FSM with registered FIFO write port, error pulses and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      exp_cnt  <= '0;
      tx_we    <= 1'b0;
      tx_data  <= '0;
      len_err  <= 1'b0;
      sop_err  <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      tx_we   <= 1'b0;
      len_err <= 1'b0;
      sop_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_sop) begin
              sop_err <= 1'b1;
            end else if (!len_ok) begin
              drop_cnt <= sat_inc(drop_cnt);
              state    <= DROP;
            end else if (fits) begin
              tx_we   <= 1'b1;
              tx_data <= header;
              exp_cnt <= need - LEN_W'(1);
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            tx_we   <= 1'b1;
            tx_data <= in_data;
            exp_cnt <= exp_cnt - LEN_W'(1);
            if (exp_cnt == LEN_W'(1)) begin
              pkt_cnt <= sat_inc(pkt_cnt);
              if (in_eop) begin
                state <= IDLE;
              end else begin
                len_err <= 1'b1;
                state   <= DROP;
              end
            end else if (in_eop) begin
              len_err <= 1'b1;
              state   <= PAD;
            end
          end
        end
        PAD: begin
          if (!tx_full) begin
            tx_we   <= 1'b1;
            tx_data <= '0;
            exp_cnt <= exp_cnt - LEN_W'(1);
            if (exp_cnt == LEN_W'(1)) begin
              pkt_cnt <= sat_inc(pkt_cnt);
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          if (in_valid && in_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pkt_admit.sv
// tb/tb_tx_pkt_admit.sv - randomized self-checking bench for tx_pkt_admit
module tb_tx_pkt_admit;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [13:0] in_len;
  logic        tx_we;
  logic [63:0] tx_data;
  logic        tx_full;
  logic [12:0] tx_usedw;
  logic        len_err;
  logic        sop_err;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  tx_pkt_admit #(.DEPTH_QWD(DEPTH), .LEN_W(14)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_len(in_len),
    .tx_we(tx_we), .tx_data(tx_data), .tx_full(tx_full), .tx_usedw(tx_usedw),
    .len_err(len_err), .sop_err(sop_err), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  int          wr_cyc[$];
  int          cyc = 0;
  int          exp_pkt = 0, exp_drop = 0, exp_lerr = 0, exp_serr = 0;
  int          n_lerr = 0, n_serr = 0;
  bit          mon_en = 1'b1;
  bit          fifo_en = 1'b0;
  int          occ_cnt = 0, max_occ = 0;
  bit          we_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every FIFO write must match the next word the frame model predicted
  always @(negedge clk) begin
    if (len_err) n_lerr++;
    if (sop_err) n_serr++;
    if (tx_we) begin
      wr_cyc.push_back(cyc);
      if (mon_en) begin
        if (exp_q.size() == 0) check("extra_write", 64'(exp_q.size()), 64'd1);
        else check("wr_data", tx_data, exp_q.pop_front());
      end
    end
  end

  // FIFO occupancy model with a random reader; a write lands one cycle after tx_we
  always @(negedge clk) begin
    if (fifo_en) begin
      if (we_prev) occ_cnt++;
      if (occ_cnt > max_occ) max_occ = occ_cnt;
      if (occ_cnt > 0 && $urandom_range(0, 1) == 1) occ_cnt--;
      tx_usedw = 13'(occ_cnt);
      tx_full  = (occ_cnt >= DEPTH);
    end
    we_prev = tx_we;
  end

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic drive_beat(input logic [63:0] d, input bit sop, input bit eop, input int len);
    bit acc;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_len   = 14'(len);
    forever begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 3000) begin
        check("hs_timeout", 64'(n), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "handshake timeout");
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_input();
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Frame-level reference: expected FIFO words and counter effects from the length rules
  task automatic send_frame(input int len, input int nb, input bit noisy);
    logic [63:0] d[$];
    int need, data;
    for (int i = 0; i < nb; i++) d.push_back({$urandom, $urandom});
    need = (len + 7) / 8 + 1;
    if (len == 0 || need > DEPTH) begin
      exp_drop++;
    end else begin
      data = need - 1;
      exp_q.push_back({1'b1, 49'd0, 14'(len)});
      for (int i = 0; i < data; i++) exp_q.push_back((i < nb) ? d[i] : 64'd0);
      if (nb != data) exp_lerr++;
      exp_pkt++;
    end
    for (int i = 0; i < nb; i++) begin
      if (noisy && i > 0 && $urandom_range(0, 7) == 0) idle_input();
      drive_beat(d[i], (i == 0) || (noisy && $urandom_range(0, 9) == 0), i == nb - 1, len);
    end
    idle_input();
  endtask

  task automatic send_stray();
    drive_beat({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 0);
    exp_serr++;
    idle_input();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int len, nb, need, data, r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    in_len = '0; tx_full = 1'b0; tx_usedw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_tx_we", 64'(tx_we), 64'd0);
    check("rst_tx_data", tx_data, 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_sop_err", 64'(sop_err), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 24-byte frame into an empty FIFO: four back-to-back writes
    wr_cyc.delete();
    send_frame(24, 3, 1'b0);
    wait_drain();
    check("f24_wr_count", 64'(wr_cyc.size()), 64'd4);
    if (wr_cyc.size() == 4) check("f24_consecutive", 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
    check("f24_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Space stall: need 6 with 3 free, then release with exactly 6 free
    tx_usedw = 13'd29;
    fork
      send_frame(40, 5, 1'b0);
      begin
        repeat (6) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_tx_we", 64'(tx_we), 64'd0);
        tx_usedw = 13'd26;
        @(negedge clk);
        check("admit_tx_we", 64'(tx_we), 64'd1);
        check("admit_header", tx_data, 64'h8000_0000_0000_0028);
      end
    join
    wait_drain();
    tx_usedw = 13'd0;

    // Short frame padded, overlong frame truncated, illegal lengths dropped
    send_frame(16, 1, 1'b0);
    wait_drain();
    check("pad_len_err", 64'(n_lerr), 64'(exp_lerr));
    send_frame(8, 2, 1'b0);
    wait_drain();
    check("trunc_len_err", 64'(n_lerr), 64'(exp_lerr));
    wr_cyc.delete();
    send_frame(0, 3, 1'b0);
    send_frame(300, 2, 1'b0);
    wait_drain();
    check("drop_no_writes", 64'(wr_cyc.size()), 64'd0);
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    send_stray();
    repeat (2) @(negedge clk);
    check("stray_sop_err", 64'(n_serr), 64'(exp_serr));

    // Reset in the middle of DATA
    mon_en = 1'b0;
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, 64);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 64);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 64);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_we", 64'(tx_we), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    @(negedge clk);
    mon_en = 1'b1;
    send_frame(24, 3, 1'b0);
    wait_drain();
    check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Randomized frames against a draining FIFO
    occ_cnt = 0;
    we_prev = 1'b0;
    fifo_en = 1'b1;
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 9) == 0) send_stray();
      r = $urandom_range(0, 19);
      if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(249, 2000);
      else len = $urandom_range(1, 248);
      need = (len + 7) / 8 + 1;
      data = need - 1;
      if (len == 0 || need > DEPTH) begin
        nb = $urandom_range(1, 4);
      end else begin
        r = $urandom_range(0, 9);
        if (r < 7) nb = data;
        else if (r == 7) nb = (data > 1) ? $urandom_range(1, data - 1) : data;
        else nb = data + $urandom_range(1, 3);
      end
      send_frame(len, nb, 1'b1);
    end
    wait_drain();
    check("final_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    check("final_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("final_len_err", 64'(n_lerr), 64'(exp_lerr));
    check("final_sop_err", 64'(n_serr), 64'(exp_serr));
    check("fifo_no_overflow", 64'(max_occ <= DEPTH), 64'd1);
    finish_run();
  end

endmodule
